// File: rtl/nios2_cpu_mul_sequencer_if.sv
// Requester-side handshake bundle for the multiply sequencer.
interface nios2_cpu_mul_sequencer_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    // Sequencer side
    modport slave (
        input  flush,
        input  req_valid,
        input  req_op,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_result
    );

    // Execute-stage requester side
    modport master (
        output flush,
        output req_valid,
        output req_op,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_result
    );
endinterface

// File: rtl/nios2_cpu_mul_sequencer.sv
// Sequences the 3-partial-product 16x16 multiplier cell through one pass (MUL)
// or two passes plus sign corrections (MULXSS/MULXSU/MULXUU).
module nios2_cpu_mul_sequencer (
    input  logic                             clk,
    input  logic                             reset_n,
    nios2_cpu_mul_sequencer_if.slave         bus,
    output logic [31:0]                      mc_src1,
    output logic [31:0]                      mc_src2,
    output logic                             mc_en,
    input  logic [31:0]                      mc_p1,
    input  logic [31:0]                      mc_p2,
    input  logic [31:0]                      mc_p3
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned ACC_W  = 50;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXUU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE1 = 3'd1,
        S_CAP1   = 3'd2,
        S_ISSUE2 = 3'd3,
        S_CAP2   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                mc_en_q, mc_en_d;
    logic [DATA_W-1:0]   mc_src1_q, mc_src1_d;
    logic [DATA_W-1:0]   mc_src2_q, mc_src2_d;
    logic [DATA_W-1:0]   hu;
    logic [DATA_W-1:0]   high_corr;

    // High word of the unsigned product, then signed corrections for the op
    always_comb begin
        hu        = DATA_W'(acc_q[ACC_W-1:DATA_W]) + mc_p1;
        high_corr = hu;
        if ((op_q != OP_MULXUU) && a_q[DATA_W-1]) begin
            high_corr = high_corr - b_q;
        end
        if ((op_q == OP_MULXSS) && b_q[DATA_W-1]) begin
            high_corr = high_corr - a_q;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_d    = bus.req_op;
                        a_d     = bus.req_a;
                        b_d     = bus.req_b;
                        state_d = S_ISSUE1;
                    end
                end
                S_ISSUE1: state_d = S_CAP1;
                S_CAP1: begin
                    acc_d = ACC_W'(mc_p1)
                          + (ACC_W'(mc_p2) << HALF_W)
                          + (ACC_W'(mc_p3) << HALF_W);
                    if (op_q == OP_MUL) begin
                        result_d = acc_d[DATA_W-1:0];
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_ISSUE2;
                    end
                end
                S_ISSUE2: state_d = S_CAP2;
                S_CAP2: begin
                    result_d = high_corr;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        mc_en_d     = (state_d == S_ISSUE1) || (state_d == S_ISSUE2);
        mc_src1_d   = '0;
        mc_src2_d   = '0;
        if (state_d == S_ISSUE1) begin
            mc_src1_d = a_d;
            mc_src2_d = b_d;
        end else if (state_d == S_ISSUE2) begin
            mc_src1_d = {HALF_W'(0), a_d[DATA_W-1:HALF_W]};
            mc_src2_d = {HALF_W'(0), b_d[DATA_W-1:HALF_W]};
        end
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            mc_en_q     <= 1'b0;
            mc_src1_q   <= '0;
            mc_src2_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mc_en_q     <= mc_en_d;
            mc_src1_q   <= mc_src1_d;
            mc_src2_q   <= mc_src2_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign mc_en          = mc_en_q;
    assign mc_src1        = mc_src1_q;
    assign mc_src2        = mc_src2_q;

endmodule

// File: tb/tb_nios2_cpu_mul_sequencer.sv
// Bench for nios2_cpu_mul_sequencer: cell model, 64-bit reference multiply.
module tb_nios2_cpu_mul_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] mc_src1, mc_src2;
    logic        mc_en;
    logic [31:0] mc_p1, mc_p2, mc_p3;
    int          n_checks;
    int          n_fail;
    int          cycle;

    nios2_cpu_mul_sequencer_if bus ();

    nios2_cpu_mul_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .mc_src1 (mc_src1),
        .mc_src2 (mc_src2),
        .mc_en   (mc_en),
        .mc_p1   (mc_p1),
        .mc_p2   (mc_p2),
        .mc_p3   (mc_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Multiplier cell: one registered stage gated by its enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mc_p1 <= '0;
            mc_p2 <= '0;
            mc_p3 <= '0;
        end else if (mc_en) begin
            mc_p1 <= 32'(mc_src1[15:0]) * 32'(mc_src2[15:0]);
            mc_p2 <= 32'(mc_src1[15:0]) * 32'(mc_src2[31:16]);
            mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
        end
    end

    // Reference: Nios II multiply semantics via 64-bit arithmetic
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pu;
        longint      sa, sb, ps;
        pu = {32'h0, a} * {32'h0, b};
        case (op)
            2'b00: return pu[31:0];
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ps = sa * sb;
                return ps[63:32];
            end
            2'b10: begin
                sa = longint'($signed(a));
                sb = longint'({32'h0, b});
                ps = sa * sb;
                return ps[63:32];
            end
            default: return pu[63:32];
        endcase
    endfunction

    // One full request/response with rsp_ready high; caller is at a negedge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          exp_lat;
        int          got;
        logic        exp_en;
        logic [31:0] exp_s1, exp_s2, exp_res;
        exp_lat = (op == 2'b00) ? 3 : 5;
        exp_res = ref_mul(op, a, b);
        got     = -1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_at_issue: got %b want 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.req_a     = $urandom;
            bus.req_b     = $urandom;
            if (n <= exp_lat) begin
                exp_en = (n == 1) || ((n == 3) && (op != 2'b00));
                exp_s1 = (n == 1) ? a : (exp_en ? {16'h0, a[31:16]} : 32'h0);
                exp_s2 = (n == 1) ? b : (exp_en ? {16'h0, b[31:16]} : 32'h0);
                n_checks++;
                if (mc_en !== exp_en || mc_src1 !== exp_s1 || mc_src2 !== exp_s2) begin
                    n_fail++;
                    $display("FAIL cell_drive op=%0d cyc=%0d: got en=%b s1=%h s2=%h want en=%b s1=%h s2=%h",
                             op, n, mc_en, mc_src1, mc_src2, exp_en, exp_s1, exp_s2);
                end
            end
            if (bus.rsp_valid === 1'b1) begin
                got = n;
                break;
            end
        end
        n_checks++;
        if (got != exp_lat) begin
            n_fail++;
            $display("FAIL latency op=%0d: got %0d want %0d", op, got, exp_lat);
        end
        n_checks++;
        if (bus.rsp_result !== exp_res) begin
            n_fail++;
            $display("FAIL result op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.rsp_result, exp_res);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = 2'b00;
        bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mc_en !== 1'b0 ||
            bus.rsp_result !== 32'h0 || mc_src1 !== 32'h0 || mc_src2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b vld=%b en=%b res=%h s1=%h s2=%h want 1 0 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, mc_en, bus.rsp_result, mc_src1, mc_src2);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'h0001_0003, 32'h0002_0005);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b01, 32'h8000_0000, 32'h0000_0002);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        n_checks++;
        if (ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF) !== 32'hFFFF_FFFE ||
            ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF) !== 32'hFFFF_FFFF ||
            ref_mul(2'b00, 32'h0001_0003, 32'h0002_0005) !== 32'h000B_000F) begin
            n_fail++;
            $display("FAIL ref_model_sanity: model disagrees with known products");
        end
    endtask

    task automatic test_backpressure();
        int          got;
        logic [31:0] exp1, exp2;
        exp1 = ref_mul(2'b00, 32'h1234_5678, 32'h0000_0100);
        exp2 = ref_mul(2'b00, 32'h0000_0009, 32'h0000_000B);
        got  = -1;
        bus.req_valid = 1'b1; bus.req_op = 2'b00;
        bus.req_a = 32'h1234_5678; bus.req_b = 32'h0000_0100;
        bus.rsp_ready = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.req_a = 32'h0000_0009;
            bus.req_b = 32'h0000_000B;
            if (bus.rsp_valid === 1'b1) begin
                got = n;
                break;
            end
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d want 3", got);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== exp1 || bus.req_ready !== 1'b0 || mc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold %0d: got vld=%b res=%h rdy=%b en=%b want 1 %h 0 0",
                         i, bus.rsp_valid, bus.rsp_result, bus.req_ready, mc_en, exp1);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_gap: got rdy=%b vld=%b en=%b want 1 0 0", bus.req_ready, bus.rsp_valid, mc_en);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++;
        if (mc_en !== 1'b1 || mc_src1 !== 32'h0000_0009 || mc_src2 !== 32'h0000_000B) begin
            n_fail++;
            $display("FAIL bp_second_issue: got en=%b s1=%h s2=%h want 1 00000009 0000000b", mc_en, mc_src1, mc_src2);
        end
        got = -1;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = n;
                break;
            end
        end
        n_checks++;
        if (got != 3 || bus.rsp_result !== exp2) begin
            n_fail++;
            $display("FAIL bp_second_result: got lat=%0d res=%h want 3 %h", got, bus.rsp_result, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        bus.req_valid = 1'b1; bus.req_op = 2'b11;
        bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'hCAFE_F00D;
        bus.rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        n_checks++;
        if (mc_en !== 1'b1 || mc_src1 !== 32'h0000_DEAD) begin
            n_fail++;
            $display("FAIL flush_in_issue2: got en=%b s1=%h want 1 0000dead", mc_en, mc_src1);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mc_en !== 1'b0 || mc_src1 !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_to_idle: got rdy=%b vld=%b en=%b s1=%h want 1 0 0 0",
                     bus.req_ready, bus.rsp_valid, mc_en, mc_src1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || mc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_response %0d: got vld=%b en=%b want 0 0", i, bus.rsp_valid, mc_en);
            end
        end
        run_op(2'b00, 32'd7, 32'd6);
    endtask

    task automatic test_reset_mid_op();
        bus.req_valid = 1'b1; bus.req_op = 2'b01;
        bus.req_a = 32'h1357_9BDF; bus.req_b = 32'h2468_ACE0;
        repeat (2) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0 ||
            mc_en !== 1'b0 || mc_src1 !== 32'h0 || mc_src2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got rdy=%b vld=%b res=%h en=%b s1=%h s2=%h want 1 0 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, mc_en, mc_src1, mc_src2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(2'b10, 32'h8000_0001, 32'hFFFF_0003);
    endtask

    task automatic test_back_to_back();
        int start;
        logic [1:0] op;
        for (int i = 0; i < 6; i++) begin
            op    = 2'((i * 3) % 4);
            start = cycle;
            run_op(op, $urandom, $urandom);
            n_checks++;
            if (cycle - start != ((op == 2'b00) ? 4 : 6)) begin
                n_fail++;
                $display("FAIL throughput op=%0d: got %0d want %0d", op, cycle - start, (op == 2'b00) ? 4 : 6);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a[31] = 1'b1;
            if (i % 7 == 0) b[31] = 1'b1;
            run_op(2'($urandom_range(0, 3)), a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cycle    = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_cpu_mul_sequencer.md
# nios2_cpu_mul_sequencer

Controls the three-partial-product 16x16 multiplier cell (p1 = a_lo·b_lo, p2 = a_lo·b_hi, p3 = a_hi·b_lo, one registered stage gated by its enable) so that it can execute full Nios II multiply instructions.
- MUL (low 32 bits) takes one pass through the cell.
- MULXSS, MULXSU and MULXUU (high 32 bits) take a second pass that computes a_hi·b_hi, followed by signed corrections.

The block sits between the execute-stage requester, which uses a valid/ready handshake, and the cell.

## Interface
Parameters: none (widths are fixed by the cell).

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of the in-flight operation
- req_valid  in  1  request offered
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  operation select: 00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
- req_a  in  32  operand A (src1)
- req_b  in  32  operand B (src2)
- rsp_valid  out  1  result available
- rsp_ready  in  1  requester takes the result
- rsp_result  out  32  result word
- mc_src1  out  32  to the cell's E_src1
- mc_src2  out  32  to the cell's E_src2
- mc_en  out  1  to the cell's M_en
- mc_p1, mc_p2, mc_p3  in  32 each  partial products from the cell

## Operation
States: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, DONE.

- **IDLE**
  - req_ready = 1.
  - On req_valid: latch op, a and b into op_r, a_r and b_r, then go to ISSUE1.
- **ISSUE1**
  - Drive mc_src1 = a_r, mc_src2 = b_r, mc_en = 1.
  - Go to CAP1.
- **CAP1**
  - Drive mc_en = 0.
  - Compute acc_r (50 bits) = mc_p1 + (mc_p2<<16) + (mc_p3<<16), with zero extension.
  - If op_r = MUL: rsp_result ← acc_r[31:0], go to DONE.
  - Otherwise go to ISSUE2.
- **ISSUE2**
  - Drive mc_src1 = {16'h0, a_r[31:16]}, mc_src2 = {16'h0, b_r[31:16]}, mc_en = 1.
  - Go to CAP2.
- **CAP2**
  - Compute hu = acc_r[49:32] + mc_p1, mod 2^32.
  - Apply corrections, all mod 2^32:
    - MULXUU: result = hu.
    - MULXSU: result = hu − (a_r[31] ? b_r : 0).
    - MULXSS: result = hu − (a_r[31] ? b_r : 0) − (b_r[31] ? a_r : 0).
  - Register the result into rsp_result and go to DONE.
- **DONE**
  - rsp_valid = 1; rsp_result is held stable.
  - On rsp_ready: go to IDLE.

Rules common to all states:
- mc_src1 and mc_src2 are 0 whenever mc_en = 0.
- mc_en is 1 only in ISSUE1 and ISSUE2.
- req_ready and rsp_valid are decoded from the state.
- Only one operation is in flight at a time. No new request is accepted in DONE, even while rsp_ready = 1; IDLE is re-entered first.
- flush, in any state:
  - Next state is IDLE and mc_en = 0 in the following cycle.
  - rsp_valid is dropped and no response is produced.
  - flush has priority over acceptance and over rsp_ready.
- Cell products are sampled only in CAP1 and CAP2. They are ignored in all other states.
- An unused upper product (p2 or p3 in pass 2) is don't-care.

## Timing
- Reset (asynchronous, reset_n = 0):
  - state = IDLE, req_ready = 1, rsp_valid = 0.
  - rsp_result = 0, mc_en = 0, mc_src1 = mc_src2 = 0.
  - acc_r, op_r, a_r and b_r = 0.
- Reset asserted mid-operation discards the operation immediately. The cell is reset by the same reset_n.
- Latency, counted from the accepting edge k (IDLE with req_valid):
  - MUL: rsp_valid is high from edge k+3.
  - MULX*: rsp_valid is high from edge k+5.
- Throughput with rsp_ready tied high:
  - One MUL every 4 cycles.
  - One MULX* every 6 cycles.
- The cell contract is a single registered stage. Products driven in ISSUEn are valid in the immediately following CAPn cycle. No wait states are inserted.
- rsp_result changes only on the transition into DONE.

## Test plan
- Reset, then idle: req_ready = 1, rsp_valid = 0, mc_en = 0. Assert reset_n = 0 while in CAP1 → all outputs return to their reset values asynchronously.
- MUL, a = 0x0001_0003, b = 0x0002_0005, rsp_ready held 1:
  - rsp_result = 0x000B_000F, rsp_valid at k+3.
  - mc_en high exactly one cycle, at k+1.
- MULXUU, a = b = 0xFFFF_FFFF → rsp_result = 0xFFFF_FFFE at k+5, with mc_en pulses at k+1 and k+3.
- MULXSS, a = b = 0xFFFF_FFFF → 0x0000_0000. MULXSU, same operands → 0xFFFF_FFFF. MULXSS, a = 0x8000_0000, b = 0x0000_0002 → 0xFFFF_FFFF.
- Backpressure: MUL with rsp_ready = 0 for 5 cycles.
  - rsp_valid and rsp_result hold and req_ready stays 0, while req_valid is held high with a second request.
  - The second request is accepted only after the response handshake plus one IDLE cycle.
- flush asserted in ISSUE2 of a MULXUU:
  - No response is produced and IDLE is re-entered the next cycle.
  - A following MUL 7×6 returns 42 with normal latency.
